// File: rtl/base64_pkg.sv
// Shared types and constants for the streaming Base64 decoder.
// Optional feature macro used by this codebase slice: BASE64_URL_EN
// (URL-safe alphabet, '-' = 62 and '_' = 63).
package base64_pkg;

  // Decoder FSM states.
  typedef enum logic [2:0] {
    COLLECT = 3'd0,
    PAD2    = 3'd1,
    EMIT    = 3'd2,
    FINAL   = 3'd3,
    ERR     = 3'd4
  } state_t;

  // Special characters.
  localparam logic [6:0] CH_PAD = 7'h3D;
  localparam logic [6:0] CH_CR  = 7'h0D;
  localparam logic [6:0] CH_LF  = 7'h0A;

  // Classification of one incoming ASCII character.
  // A character with none of valid/is_pad/is_ws set is invalid.
  typedef struct packed {
    logic       valid;   // member of the active alphabet, sextet holds its value
    logic       is_pad;  // '='
    logic       is_ws;   // CR/LF, only when whitespace skipping is enabled
    logic [5:0] sextet;
  } char_class_t;

  // Picks byte i (0 = most significant) out of a 24-bit quad.
  function automatic logic [7:0] quad_byte(logic [23:0] q, logic [1:0] i);
    case (i)
      2'd0:    return q[23:16];
      2'd1:    return q[15:8];
      default: return q[7:0];
    endcase
  endfunction

endpackage

// File: rtl/base64_decoder_if.sv
// Character-in / byte-out channel of the Base64 decoder.
//
// Handshake: the character side is valid/ready. A character transfers on a
// rising clock edge where dec && rdy are both 1; the source must hold
// data_in stable while dec is 1 and rdy is 0, and rdy never depends
// combinationally on dec. The byte side has no back-pressure: data_out is
// meaningful only in cycles where en is 1, one byte per cycle.
interface base64_decoder_if;
  logic       dec;
  logic [6:0] data_in;
  logic       rdy;
  logic       en;
  logic [7:0] data_out;
  logic       err;
  logic       done;

  // Character source / byte sink side (testbench, UART FIFO, ...).
  modport master (
    output dec, data_in,
    input  rdy, en, data_out, err, done
  );

  // Decoder side.
  modport slave (
    input  dec, data_in,
    output rdy, en, data_out, err, done
  );
endinterface

// File: rtl/base64_char_map.sv
// Combinational ASCII to character-class lookup for the Base64 decoder.
// Honours BASE64_URL_EN (URL-safe alphabet) and the LF_SKIP parameter.
module base64_char_map
  import base64_pkg::*;
#(
  parameter bit LF_SKIP = 1'b1
) (
  input  logic [6:0]  ch,
  output char_class_t cls
);

  // Map one character to its sextet value or special class.
  always_comb begin
    cls = '0;
    if (ch >= 7'h41 && ch <= 7'h5A) begin
      // 'A'..'Z' -> 0..25
      cls.valid  = 1'b1;
      cls.sextet = 6'(ch - 7'h41);
    end else if (ch >= 7'h61 && ch <= 7'h7A) begin
      // 'a'..'z' -> 26..51
      cls.valid  = 1'b1;
      cls.sextet = 6'(ch - 7'h61 + 7'd26);
    end else if (ch >= 7'h30 && ch <= 7'h39) begin
      // '0'..'9' -> 52..61
      cls.valid  = 1'b1;
      cls.sextet = 6'(ch - 7'h30 + 7'd52);
`ifdef BASE64_URL_EN
    end else if (ch == 7'h2D) begin
      // '-'
      cls.valid  = 1'b1;
      cls.sextet = 6'd62;
    end else if (ch == 7'h5F) begin
      // '_'
      cls.valid  = 1'b1;
      cls.sextet = 6'd63;
`else
    end else if (ch == 7'h2B) begin
      // '+'
      cls.valid  = 1'b1;
      cls.sextet = 6'd62;
    end else if (ch == 7'h2F) begin
      // '/'
      cls.valid  = 1'b1;
      cls.sextet = 6'd63;
`endif
    end else if (ch == CH_PAD) begin
      cls.is_pad = 1'b1;
    end else if (LF_SKIP && (ch == CH_CR || ch == CH_LF)) begin
      cls.is_ws  = 1'b1;
    end
  end

endmodule

// File: rtl/base64_decoder.sv
// Streaming Base64 decoder: takes one ASCII character per handshake, packs
// four sextets into a 24-bit quad and emits the decoded bytes one per cycle.
// '=' padding ends a frame; malformed input raises a sticky err that only
// reset or start clears.
// Optional feature macro: BASE64_URL_EN (selects the URL-safe alphabet in
// base64_char_map).
module base64_decoder
  import base64_pkg::*;
#(
  parameter bit LF_SKIP   = 1'b1,  // CR/LF are ignored whitespace
  parameter bit CHK_TRAIL = 1'b1   // nonzero discarded bits in a padded quad are an error
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  base64_decoder_if.slave   bus,
  output state_t            dbg_state
);

  state_t      state;
  logic [1:0]  cnt;        // sextets collected in the current quad
  logic [23:0] quad;       // sextet shift register
  logic [1:0]  nbytes;     // bytes to emit for the current quad
  logic [1:0]  idx;        // next byte to emit
  logic        terminal;   // current quad was padded: frame ends after it
  logic        trail_bad;  // padded quad had nonzero discarded bits
  logic        rdy_q;
  logic        en_q;
  logic [7:0]  data_q;
  logic        err_q;
  logic        done_q;

  char_class_t cls;
  logic        take;
  logic        bad_char;

  base64_char_map #(
    .LF_SKIP (LF_SKIP)
  ) u_char_map (
    .ch  (bus.data_in),
    .cls (cls)
  );

  assign take     = bus.dec && rdy_q;
  assign bad_char = !(cls.valid || cls.is_pad || cls.is_ws);

  assign bus.rdy      = rdy_q;
  assign bus.en       = en_q;
  assign bus.data_out = data_q;
  assign bus.err      = err_q;
  assign bus.done     = done_q;
  assign dbg_state    = state;

  // Decoder FSM with registered handshake and byte outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= COLLECT;
      cnt       <= 2'd0;
      quad      <= 24'd0;
      nbytes    <= 2'd0;
      idx       <= 2'd0;
      terminal  <= 1'b0;
      trail_bad <= 1'b0;
      rdy_q     <= 1'b1;
      en_q      <= 1'b0;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      // Frame restart wins over everything, including a quad mid-emission.
      state     <= COLLECT;
      cnt       <= 2'd0;
      quad      <= 24'd0;
      nbytes    <= 2'd0;
      idx       <= 2'd0;
      terminal  <= 1'b0;
      trail_bad <= 1'b0;
      rdy_q     <= 1'b1;
      en_q      <= 1'b0;
      data_q    <= 8'h00;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      case (state)
        COLLECT: begin
          if (take) begin
            if (cls.valid) begin
              quad <= {quad[17:0], cls.sextet};
              cnt  <= cnt + 2'd1;
              if (cnt == 2'd3) begin
                state     <= EMIT;
                nbytes    <= 2'd3;
                idx       <= 2'd0;
                terminal  <= 1'b0;
                trail_bad <= 1'b0;
                rdy_q     <= 1'b0;
              end
            end else if (cls.is_pad) begin
              if (cnt == 2'd2) begin
                state <= PAD2;
              end else if (cnt == 2'd3) begin
                // "xxx=": two bytes, the last sextet's low 2 bits are dropped.
                quad      <= {quad[17:0], 6'd0};
                state     <= EMIT;
                nbytes    <= 2'd2;
                idx       <= 2'd0;
                terminal  <= 1'b1;
                trail_bad <= CHK_TRAIL && (quad[1:0] != 2'b00);
                rdy_q     <= 1'b0;
              end else begin
                state <= ERR;
                err_q <= 1'b1;
              end
            end else if (bad_char) begin
              state <= ERR;
              err_q <= 1'b1;
            end
          end
        end

        PAD2: begin
          if (take) begin
            if (cls.is_pad) begin
              // "xx==": one byte, the second sextet's low 4 bits are dropped.
              quad      <= {quad[11:0], 12'd0};
              state     <= EMIT;
              nbytes    <= 2'd1;
              idx       <= 2'd0;
              terminal  <= 1'b1;
              trail_bad <= CHK_TRAIL && (quad[3:0] != 4'b0000);
              rdy_q     <= 1'b0;
            end else if (!cls.is_ws) begin
              state <= ERR;
              err_q <= 1'b1;
            end
          end
        end

        EMIT: begin
          en_q   <= 1'b1;
          data_q <= quad_byte(quad, idx);
          idx    <= idx + 2'd1;
          if (idx == nbytes - 2'd1) begin
            rdy_q  <= 1'b1;
            cnt    <= 2'd0;
            done_q <= terminal;
            if (!terminal) begin
              state <= COLLECT;
            end else if (trail_bad) begin
              state <= ERR;
              err_q <= 1'b1;
            end else begin
              state <= FINAL;
            end
          end
        end

        FINAL: begin
          if (take && !cls.is_ws) begin
            state <= ERR;
            err_q <= 1'b1;
          end
        end

        ERR: begin
          err_q <= 1'b1;
        end

        default: begin
          state <= ERR;
          err_q <= 1'b1;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_base64_decoder.sv
// Testbench for base64_decoder. Two decoders share one character stream:
// dut_a uses LF_SKIP=1, CHK_TRAIL=1 and dut_b uses LF_SKIP=0, CHK_TRAIL=0.
// Build with or without BASE64_URL_EN; expectations follow the macro.
module tb_base64_decoder;
  import base64_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  logic   start;
  state_t st_a;
  state_t st_b;

  base64_decoder_if bus_a ();
  base64_decoder_if bus_b ();

  base64_decoder #(.LF_SKIP(1'b1), .CHK_TRAIL(1'b1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(bus_a.slave), .dbg_state(st_a)
  );
  base64_decoder #(.LF_SKIP(1'b0), .CHK_TRAIL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(bus_b.slave), .dbg_state(st_b)
  );

  assign bus_b.dec     = bus_a.dec;
  assign bus_b.data_in = bus_a.data_in;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_a[$];   // {done, byte}
  logic [8:0] exp_b[$];
  logic [8:0] e_a;
  logic [8:0] e_b;
  logic [8:0] m_q[$];     // reference model output
  bit         m_err;
  byte        cur[$];     // character stream of the current frame

`ifdef BASE64_URL_EN
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789-_";
`else
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
`endif

  typedef struct {
    string       s;
    int          n;
    logic [47:0] bytes;   // expected bytes of dut_a, left aligned
    bit          pad;     // done expected with the last byte
    bit          err_a;
    bit          err_b;
  } vec_t;
  vec_t vecs[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    errors++;
    $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  // Byte monitors: every en must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus_a.en) begin
        if (exp_a.size() == 0) fail("a_extra_byte", {23'd0, bus_a.done, bus_a.data_out}, 0);
        else begin
          e_a = exp_a.pop_front();
          check("a_byte", {23'd0, bus_a.done, bus_a.data_out}, {23'd0, e_a});
        end
      end else if (bus_a.done) fail("a_done_without_en", 1, 0);
      if (bus_b.en) begin
        if (exp_b.size() == 0) fail("b_extra_byte", {23'd0, bus_b.done, bus_b.data_out}, 0);
        else begin
          e_b = exp_b.pop_front();
          check("b_byte", {23'd0, bus_b.done, bus_b.data_out}, {23'd0, e_b});
        end
      end else if (bus_b.done) fail("b_done_without_en", 1, 0);
    end
  end

  // ---------------- reference model ----------------
  // -1 invalid, -2 pad, otherwise the alphabet position.
  function automatic int ref_val(byte c);
    if (c == 8'h3D) return -2;
    for (int i = 0; i < 64; i++) if (alpha[i] == c) return i;
    return -1;
  endfunction

  // Decodes cur[] by the format rules: whitespace removed, groups of four,
  // padding only as "xx==" / "xxx=", nothing but whitespace after padding.
  function automatic void model(bit lf, bit chk);
    int g[$];
    bit fin;
    int v;
    int val;
    int npad;
    m_q.delete();
    m_err = 1'b0;
    fin   = 1'b0;
    foreach (cur[i]) begin
      if (m_err) break;
      if (lf && (cur[i] == 8'h0D || cur[i] == 8'h0A)) continue;
      if (fin) begin
        m_err = 1'b1;
        break;
      end
      v = ref_val(cur[i]);
      if (v == -1) m_err = 1'b1;
      else if (v == -2 && g.size() < 2) m_err = 1'b1;
      else if (v != -2 && g.size() == 3 && g[2] == -2) m_err = 1'b1;
      else begin
        g.push_back(v);
        if (g.size() == 4) begin
          val  = 0;
          npad = 0;
          foreach (g[k]) begin
            val = val * 64 + ((g[k] < 0) ? 0 : g[k]);
            if (g[k] < 0) npad++;
          end
          for (int k = 0; k < 3 - npad; k++)
            m_q.push_back({1'((npad > 0) && (k == 2 - npad)), 8'((val >> (16 - 8 * k)) & 255)});
          if (npad > 0) begin
            fin = 1'b1;
            if (chk && ((npad == 1 && (val & 255) != 0) || (npad == 2 && (val & 65535) != 0)))
              m_err = 1'b1;
          end
          g.delete();
        end
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at a negedge; holds dec high between characters.
  task automatic send_char(logic [6:0] c, bit gaps);
    int n;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus_a.dec = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bus_a.dec     = 1'b1;
    bus_a.data_in = c;
    n = 0;
    while (bus_a.rdy !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) fail("rdy_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_cur(bit gaps);
    foreach (cur[i]) send_char(cur[i][6:0], gaps);
    bus_a.dec = 1'b0;
  endtask

  task automatic str_to_cur(string s);
    cur.delete();
    for (int i = 0; i < s.len(); i++) cur.push_back(s[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_frame(string tag, bit ea, bit eb);
    int n;
    bus_a.dec = 1'b0;
    n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) fail({tag, "_drain"}, exp_a.size() + exp_b.size(), 0);
    repeat (4) @(negedge clk);
    check({tag, "_err_a"}, bus_a.err, ea);
    check({tag, "_err_b"}, bus_b.err, eb);
    exp_a.delete();
    exp_b.delete();
  endtask

  function automatic void add(string s, int n, logic [47:0] b, bit pad, bit ea, bit eb);
    vec_t v;
    v.s = s; v.n = n; v.bytes = b; v.pad = pad; v.err_a = ea; v.err_b = eb;
    vecs.push_back(v);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int padn;
    int nq;
    bit ea;
    bit eb;

    reset = 1'b1;
    start = 1'b0;
    bus_a.dec = 1'b0;
    bus_a.data_in = 7'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rdy", bus_a.rdy, 1);
    check("rst_en", bus_a.en, 0);
    check("rst_data", bus_a.data_out, 8'h00);
    check("rst_err", bus_a.err, 0);
    check("rst_done", bus_a.done, 0);
    check("rst_state", st_a, COLLECT);

    // Vector table: expected bytes of dut_a worked out by hand.
    add("TWFu",         3, 48'h4D616E000000, 0, 0, 0);
    add("TWE=",         2, 48'h4D6100000000, 1, 0, 0);
    add("TWE=A",        2, 48'h4D6100000000, 1, 1, 1);
    add("TQ==",         1, 48'h4D0000000000, 1, 0, 0);
    add("TR==",         1, 48'h4D0000000000, 1, 1, 0);
    add("TW*A",         0, 48'h0,            0, 1, 1);
    add("TW\015\012Fu", 3, 48'h4D616E000000, 0, 0, 1);
`ifdef BASE64_URL_EN
    add("-_8A",         3, 48'hFBFF00000000, 0, 0, 0);
    add("-_-_",         3, 48'hFBFFBF000000, 0, 0, 0);
    add("+/+/",         0, 48'h0,            0, 1, 1);
`else
    add("-_8A",         0, 48'h0,            0, 1, 1);
    add("+/+/",         3, 48'hFBFFBF000000, 0, 0, 0);
`endif
    add("TWFuTWFu",     6, 48'h4D616E4D616E, 0, 0, 0);
    add("T=",           0, 48'h0,            0, 1, 1);
    add("TW=A",         0, 48'h0,            0, 1, 1);
    add("TWE=\012",     2, 48'h4D6100000000, 1, 0, 1);
    add("AAAA9999",     6, 48'h000000F7DF7D, 0, 0, 0);
    add("TWF",          0, 48'h0,            0, 0, 0);

    foreach (vecs[i]) begin
      pulse_start();
      str_to_cur(vecs[i].s);
      for (int k = 0; k < vecs[i].n; k++)
        exp_a.push_back({1'(vecs[i].pad && k == vecs[i].n - 1), vecs[i].bytes[47 - 8 * k -: 8]});
      model(1'b0, 1'b0);
      foreach (m_q[k]) exp_b.push_back(m_q[k]);
      send_cur(1'b0);
      finish_frame({"vec_", vecs[i].s}, vecs[i].err_a, vecs[i].err_b);
    end

    // Latency: rdy drops right after the quad-completing character, bytes a cycle later.
    pulse_start();
    str_to_cur("TWFu");
    model(1'b1, 1'b1);
    foreach (m_q[k]) exp_a.push_back(m_q[k]);
    foreach (m_q[k]) exp_b.push_back(m_q[k]);
    for (int k = 0; k < 3; k++) send_char(cur[k][6:0], 1'b0);
    send_char(7'h75, 1'b0);
    check("lat_rdy_low", bus_a.rdy, 0);
    check("lat_en_not_yet", bus_a.en, 0);
    bus_a.dec = 1'b0;
    @(negedge clk);
    check("lat_first_en", bus_a.en, 1);
    @(negedge clk);
    check("lat_second_en", bus_a.en, 1);
    finish_frame("latency", 0, 0);

    // Error flag appears the cycle after the invalid character.
    pulse_start();
    send_char(7'h54, 1'b0);
    send_char(7'h57, 1'b0);
    check("err_before_bad", bus_a.err, 0);
    send_char(7'h2A, 1'b0);
    check("err_after_bad", bus_a.err, 1);
    check("err_state", st_a, ERR);
    send_char(7'h41, 1'b0);
    finish_frame("bad_char", 1, 1);
    pulse_start();
    check("err_cleared_by_start", bus_a.err, 0);

    // Restart during emission: only the first byte survives.
    str_to_cur("TWFu");
    exp_a.push_back({1'b0, 8'h4D});
    exp_b.push_back({1'b0, 8'h4D});
    send_cur(1'b0);
    n = 0;
    while (!bus_a.en && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) fail("restart_en_timeout", 0, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("restart_rdy", bus_a.rdy, 1);
    check("restart_en", bus_a.en, 0);
    check("restart_state", st_a, COLLECT);
    finish_frame("restart", 0, 0);

    // Randomized frames against the reference model.
    for (int f = 0; f < 60; f++) begin
      pulse_start();
      cur.delete();
      nq = $urandom_range(1, 3);
      for (int q = 0; q < nq; q++) begin
        padn = (q == nq - 1) ? $urandom_range(0, 2) : 0;
        for (int k = 0; k < 4; k++) begin
          if ($urandom_range(0, 9) == 0) cur.push_back(($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
          if (k >= 4 - padn) cur.push_back(8'h3D);
          else cur.push_back(alpha[$urandom_range(0, 63)]);
        end
      end
      if ($urandom_range(0, 5) == 0) cur[$urandom_range(0, cur.size() - 1)] = 8'($urandom_range(1, 127));
      if ($urandom_range(0, 5) == 0) cur.push_back(8'($urandom_range(1, 127)));
      model(1'b1, 1'b1);
      foreach (m_q[k]) exp_a.push_back(m_q[k]);
      ea = m_err;
      model(1'b0, 1'b0);
      foreach (m_q[k]) exp_b.push_back(m_q[k]);
      eb = m_err;
      send_cur(1'b1);
      finish_frame("rnd", ea, eb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
